// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_det_pkg;

    // FSM state encoding, also exported on state_out for debug.
    typedef enum logic [1:0] {
        FILL  = 2'b00,
        ARMED = 2'b01,
        MATCH = 2'b10
    } state_t;

    // Standard patterns, MSB is the first bit on the line.
    localparam logic [3:0] SYNC_1011 = 4'b1011;
    localparam logic [3:0] SYNC_0110 = 4'b0110;
    localparam logic [7:0] SYNC_A5   = 8'hA5;

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial-stream, control and status bundle for seq_detector_param.
interface seq_detector_param_if #(
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               sequence_valid;
    logic               sequence_in;
    logic               overlap_en;
    logic               pattern_load;
    logic [SEQ_LEN-1:0] pattern_in;
    logic               count_clr;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic [1:0]         state_out;

    // Front-end / controller side.
    modport master (
        output sequence_valid, sequence_in, overlap_en,
        output pattern_load, pattern_in, count_clr,
        input  detector_out, match_count, state_out
    );

    // Detector side.
    modport slave (
        input  sequence_valid, sequence_in, overlap_en,
        input  pattern_load, pattern_in, count_clr,
        output detector_out, match_count, state_out
    );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter; clear beats increment, never wraps.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    // Count up until all-ones, then hold.
    always_ff @(posedge clock) begin
        if (reset || clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap control and match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 SEQ_LEN     = 4,
    parameter logic [SEQ_LEN-1:0] DEF_PATTERN = SYNC_1011,
    parameter int                 CNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    seq_detector_param_if.slave bus
);
    localparam int                FILL_W   = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(SEQ_LEN - 1);

    // Only the newest SEQ_LEN-1 bits are kept: the full window is always
    // formed together with the incoming bit, so the oldest bit is never read.
    logic [SEQ_LEN-2:0] history;
    logic [SEQ_LEN-1:0] pattern;
    logic [SEQ_LEN-1:0] window;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_inc;
    logic               bit_ok;
    logic               hit;
    logic               det_q;
    state_t             state, state_nxt;

    // Window compare; a bit arriving with pattern_load is dropped.
    always_comb begin
        window   = {history, bus.sequence_in};
        bit_ok   = bus.sequence_valid & ~bus.pattern_load;
        hit      = bit_ok & (fill >= FILL_ARM) & (window == pattern);
        fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
    end

    // Pattern, history and fill bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            pattern <= DEF_PATTERN;
            history <= '0;
            fill    <= '0;
        end else if (bus.pattern_load) begin
            pattern <= bus.pattern_in;
            history <= '0;
            fill    <= '0;
        end else if (bus.sequence_valid) begin
            if (hit && !bus.overlap_en) begin
                // Non-overlapping: next match needs a fully fresh window.
                history <= '0;
                fill    <= '0;
            end else begin
                history <= window[SEQ_LEN-2:0];
                if (!hit)
                    fill <= fill_inc;
            end
        end
    end

    // State register and registered match pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
            det_q <= 1'b0;
        end else begin
            state <= state_nxt;
            det_q <= hit;
        end
    end

    // Next-state: idle cycles hold, loads restart, hits go to MATCH.
    always_comb begin
        state_nxt = state;
        if (bus.pattern_load)
            state_nxt = FILL;
        else if (bus.sequence_valid) begin
            if (hit)
                state_nxt = MATCH;
            else begin
                case (state)
                    FILL:    state_nxt = (fill_inc == FILL_MAX) ? ARMED : FILL;
                    ARMED:   state_nxt = ARMED;
                    MATCH:   state_nxt = bus.overlap_en ? ARMED : FILL;
                    default: state_nxt = FILL;
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (hit),
        .clr   (bus.count_clr),
        .count (bus.match_count)
    );

    assign bus.detector_out = det_q;
    assign bus.state_out    = state;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: two detectors (8-bit and 2-bit counters) share one stimulus.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ov    = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    seq_detector_param_if #(.SEQ_LEN(4), .CNT_W(8)) b8 ();
    seq_detector_param_if #(.SEQ_LEN(4), .CNT_W(2)) b2 ();

    seq_detector_param #(.SEQ_LEN(4), .DEF_PATTERN(4'b1011), .CNT_W(8)) u8 (
        .clock (clock), .reset (reset), .bus (b8)
    );
    seq_detector_param #(.SEQ_LEN(4), .DEF_PATTERN(4'b1011), .CNT_W(2)) u2 (
        .clock (clock), .reset (reset), .bus (b2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs to both DUTs; return #1 after the edge.
    task automatic step(input logic v, input logic b, input logic ld,
                        input logic [3:0] pin, input logic clr, input logic rst);
        reset = rst;
        b8.sequence_valid = v;  b2.sequence_valid = v;
        b8.sequence_in    = b;  b2.sequence_in    = b;
        b8.overlap_en     = ov; b2.overlap_en     = ov;
        b8.pattern_load   = ld; b2.pattern_load   = ld;
        b8.pattern_in     = pin; b2.pattern_in    = pin;
        b8.count_clr      = clr; b2.count_clr     = clr;
        @(posedge clock);
        #1;
    endtask

    logic [6:0] s1;
    logic [6:0] e1;
    logic [6:0] e2;
    logic [3:0] s3;
    logic [3:0] s4;

    initial begin
        s1 = 7'b1011011;
        e1 = 7'b0001001;
        e2 = 7'b0001000;
        s3 = 4'b0110;
        s4 = 4'b1011;

        // reset state
        step(1, 1, 0, 4'h0, 0, 1);
        step(1, 1, 0, 4'h0, 0, 1);
        chk("rst_det", b8.detector_out, 0);
        chk("rst_cnt", b8.match_count, 0);
        chk("rst_state", b8.state_out, FILL);

        // 1: overlapping, pulses after bits 4 and 7
        ov = 1;
        for (int i = 0; i < 7; i++) begin
            step(1, s1[6-i], 0, 4'h0, 0, 0);
            chk($sformatf("t1_det%0d", i), b8.detector_out, e1[6-i]);
            if (i == 3) chk("t1_st_match", b8.state_out, MATCH);
            if (i == 4) chk("t1_st_armed", b8.state_out, ARMED);
        end
        chk("t1_cnt8", b8.match_count, 2);
        chk("t1_cnt2", b2.match_count, 2);

        // 2: non-overlapping, one pulse only
        step(0, 0, 0, 4'h0, 0, 1);
        ov = 0;
        for (int i = 0; i < 7; i++) begin
            step(1, s1[6-i], 0, 4'h0, 0, 0);
            chk($sformatf("t2_det%0d", i), b8.detector_out, e2[6-i]);
            if (i == 4) chk("t2_st_fill", b8.state_out, FILL);
        end
        chk("t2_cnt8", b8.match_count, 1);

        // 3: load 0110 with a valid bit in the same cycle; that bit is dropped
        step(0, 0, 0, 4'h0, 0, 1);
        ov = 1;
        step(1, 1, 1, 4'b0110, 0, 0);
        chk("t3_st_load", b8.state_out, FILL);
        for (int i = 0; i < 4; i++) begin
            step(1, s3[3-i], 0, 4'h0, 0, 0);
            chk($sformatf("t3_det%0d", i), b8.detector_out, (i == 3) ? 1 : 0);
            if (i == 2) chk("t3_st_pre", b8.state_out, FILL);
        end
        chk("t3_cnt8", b8.match_count, 1);

        // 4: reload 1011, 3-cycle idle gaps between bits
        step(0, 0, 1, 4'b1011, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, s4[3-i], 0, 4'h0, 0, 0);
            chk($sformatf("t4_det%0d", i), b8.detector_out, (i == 3) ? 1 : 0);
            for (int k = 0; k < 3; k++) begin
                step(0, 1, 0, 4'h0, 0, 0);
                chk($sformatf("t4_gap%0d_%0d", i, k), b8.detector_out, 0);
            end
        end
        chk("t4_st_hold", b8.state_out, MATCH);
        chk("t4_cnt8", b8.match_count, 2);

        // 5: three more overlapping matches (0,1,1 each); 2-bit counter saturates
        for (int r = 0; r < 3; r++) begin
            step(1, 0, 0, 4'h0, 0, 0);
            step(1, 1, 0, 4'h0, 0, 0);
            step(1, 1, 0, 4'h0, 0, 0);
            chk($sformatf("t5_det%0d", r), b8.detector_out, 1);
            chk($sformatf("t5_cnt8_%0d", r), b8.match_count, 3 + r);
            chk($sformatf("t5_cnt2_%0d", r), b2.match_count, 3);
        end
        step(1, 0, 0, 4'h0, 0, 0);
        step(1, 1, 0, 4'h0, 0, 0);
        step(1, 1, 0, 4'h0, 1, 0);
        chk("t5_clr_det", b8.detector_out, 1);
        chk("t5_clr_cnt8", b8.match_count, 0);
        chk("t5_clr_cnt2", b2.match_count, 0);
        step(0, 0, 0, 4'h0, 0, 0);
        chk("t5_clr_hold", b8.match_count, 0);

        // 6: reset after 1,0,1 discards the partial pattern
        step(1, 1, 0, 4'h0, 0, 0);
        step(1, 0, 0, 4'h0, 0, 0);
        step(1, 1, 0, 4'h0, 0, 0);
        step(1, 1, 0, 4'h0, 0, 1);
        chk("t6_rst_det", b8.detector_out, 0);
        chk("t6_rst_cnt", b8.match_count, 0);
        chk("t6_rst_state", b8.state_out, FILL);
        step(1, 1, 0, 4'h0, 0, 0);
        chk("t6_det", b8.detector_out, 0);
        chk("t6_cnt", b8.match_count, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
